sync_event_arbiter: RTL

//  Collects NUM_REQ asynchronous event lines (board straps, IRQ pins, peripheral

---
 rtl/sync_evt_pkg.sv | 46 ++++
 rtl/sync_edge_det.sv | 36 +++
 rtl/sync_event_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sync_evt_pkg.sv
// ============================================================================
// Module : sync_evt_pkg
// Brief  : Shared types, constants and round-robin search for sync_event_arbiter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_evt_pkg;

    localparam int c_TIMEOUT_CYC_DEF = 255;
    localparam int c_RR_MAX          = 16;

    typedef logic [0:0] evt_state_t;

    localparam evt_state_t ST_IDLE  = 1'b0;
    localparam evt_state_t ST_GRANT = 1'b1;

    // First set bit of req at or after start, wrapping modulo n (n <= 16).
    function automatic logic [3:0] rr_find_first(
        input logic [15:0] req,
        input logic [3:0]  start,
        input int          n
    );
        logic [3:0] v_sel;
        logic       v_found;
        logic [4:0] v_sum;
        v_sel   = start;
        v_found = 1'b0;
        for (int i = 0; i < c_RR_MAX; i++) begin
            if (i < n) begin
                v_sum = {1'b0, start} + 5'(i);
                if (v_sum >= 5'(n)) begin
                    v_sum = v_sum - 5'(n);
                end
                if (!v_found && req[v_sum[3:0]]) begin
                    v_sel   = v_sum[3:0];
                    v_found = 1'b1;
                end
            end
        end
        return v_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module : sync_edge_det
// Brief  : Two-flop synchroniser plus rising-edge detect for one event line
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic CLOCK,
    input  logic RESET,
    input  logic d,
    output logic rise
);

    logic r_s0;
    logic r_s1;
    logic r_s2;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= d;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // r_s2 clears in reset, so a line held high across release yields one edge.
    assign rise = r_s1 & ~r_s2;

endmodule

`default_nettype wire

// File: rtl/sync_event_arbiter.sv
// ============================================================================
// Module : sync_event_arbiter
// Brief  : Synchronises async event lines, latches them as pending and offers
//          them one at a time, round-robin, on a valid/ready port.
//          Optional grant timeout enabled by defining SYNC_EVT_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_event_arbiter
    import sync_evt_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] async_req,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_id,
    input  logic               evt_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overflow,
    input  logic [NUM_REQ-1:0] ovf_clr,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > c_RR_MAX || TIMEOUT_CYC < 2) begin : g_param_check
        $error("sync_event_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYC >= 2");
    end

    logic [NUM_REQ-1:0] w_rise;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_overflow;
    logic [NUM_REQ-1:0] w_xfer_mask;
    logic [NUM_REQ-1:0] w_done_mask;
    logic [15:0]        w_req16;
    evt_state_t         r_state;
    logic [IDX_W-1:0]   r_id;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_grant;
    logic               w_xfer;
    logic               w_drop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
        sync_edge_det u_edge (
            .CLOCK (CLOCK),
            .RESET (RESET),
            .d     (async_req[g]),
            .rise  (w_rise[g])
        );
    end

    assign w_grant     = (r_state == ST_GRANT);
    assign w_xfer      = w_grant && evt_ready;
    assign w_xfer_mask = w_xfer ? (NUM_REQ'(1) << r_id) : '0;
    assign w_done_mask = (w_xfer || w_drop) ? (NUM_REQ'(1) << r_id) : '0;

    assign w_req16   = 16'(r_pending);
    assign w_pick    = IDX_W'(rr_find_first(w_req16, 4'(r_ptr), NUM_REQ));
    assign w_ptr_nxt = (r_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

    // Rise is OR-ed in after the clear, so a new edge beats delivery of the old one.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_done_mask) | w_rise;
            r_overflow <= (r_overflow & ~ovf_clr) | (w_rise & r_pending & ~w_xfer_mask);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_state <= ST_GRANT;
                        r_id    <= w_pick;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer || w_drop) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYNC_EVT_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout;

    // Counter reads 0 in the first GRANT cycle, so the offer lasts TIMEOUT_CYC cycles.
    assign w_drop = w_grant && !evt_ready && (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_grant || w_xfer || w_drop) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_drop) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_drop  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign evt_valid = w_grant;
    assign evt_id    = r_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire
